// File: rtl/rs_encoder237_pkg.sv
// Shared RS(255,237) constants: field definition, generator polynomial, FSM states.
package rs237_pkg;

   localparam logic [8:0]  GF_POLY    = 9'h11D;
   localparam int unsigned NUM_COEFS  = 18;
   localparam int unsigned DATA_BYTES = 237;
   localparam int unsigned SYM_W      = 8;
   localparam int unsigned CNT_W      = 8;

   typedef logic [SYM_W-1:0] sym_t;

   typedef enum logic {
      MSG = 1'b0,
      PAR = 1'b1
   } state_e;

   typedef struct packed {
      sym_t data;
      logic sop;
      logic eop;
   } cw_beat_t;

   // Shift-and-add multiply, reducing by GF_POLY whenever the top bit falls out
   function automatic sym_t gf_mul(input sym_t a, input sym_t b);
      sym_t acc;
      sym_t sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < int'(SYM_W); i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[SYM_W-1] ? ((sh << 1) ^ GF_POLY[SYM_W-1:0]) : (sh << 1);
      end
      return acc;
   endfunction

   // Expands prod (x + alpha^i), i = 1..NUM_COEFS; the monic top term is dropped
   function automatic logic [NUM_COEFS-1:0][SYM_W-1:0] gen_poly();
      logic [NUM_COEFS:0][SYM_W-1:0] g;
      sym_t root;
      g    = '0;
      g[0] = SYM_W'(1);
      root = SYM_W'(1);
      for (int i = 1; i <= int'(NUM_COEFS); i++) begin
         root = gf_mul(root, SYM_W'(2));
         for (int k = int'(NUM_COEFS); k >= 1; k--)
            g[k] = g[k-1] ^ gf_mul(g[k], root);
         g[0] = gf_mul(g[0], root);
      end
      return g[NUM_COEFS-1:0];
   endfunction

   localparam logic [NUM_COEFS-1:0][SYM_W-1:0] G = gen_poly();

endpackage

// File: rtl/rs_encoder237_if.sv
// Byte-stream bundle: message bytes in, codeword bytes out with sop/eop framing.
interface rs_encoder237_if;
   import rs237_pkg::*;

   logic in_valid;
   logic in_ready;
   sym_t in_data;
   logic out_valid;
   logic out_ready;
   sym_t out_data;
   logic out_sop;
   logic out_eop;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop
   );
endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier; a constant operand collapses to an XOR network.
module gf256_mul
   import rs237_pkg::*;
(
   input  sym_t i_a,
   input  sym_t i_b,
   output sym_t o_p
);
   assign o_p = gf_mul(i_a, i_b);
endmodule

// File: rtl/rs_encoder237.sv
// Systematic RS(255,237) encoder: passes 237 message bytes, then emits 18 parity bytes.
module rs_encoder237
   import rs237_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   rs_encoder237_if.slave  bus
);

   state_e   r_state;
   state_e   w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   sym_t     r_p  [NUM_COEFS];
   sym_t     w_gp [NUM_COEFS];
   sym_t     w_fb;
   cw_beat_t r_out;
   logic     r_out_valid;

   logic w_out_load;
   logic w_in_ready;
   logic w_in_fire;
   logic w_par_fire;
   logic w_last_msg;
   logic w_last_par;

   assign w_out_load = !r_out_valid || bus.out_ready;
   assign w_fb       = bus.in_data ^ r_p[NUM_COEFS-1];
   assign w_last_msg = (r_cnt == CNT_W'(DATA_BYTES - 1));
   assign w_last_par = (r_cnt == CNT_W'(NUM_COEFS - 1));

   for (genvar j = 0; j < int'(NUM_COEFS); j++) begin : g_mul
      gf256_mul u_mul (
         .i_a (w_fb),
         .i_b (G[j]),
         .o_p (w_gp[j])
      );
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= MSG;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MSG:     if (w_in_fire && w_last_msg)  w_state_nxt = PAR;
         PAR:     if (w_par_fire && w_last_par) w_state_nxt = MSG;
         default: w_state_nxt = MSG;
      endcase
   end

   // Handshake decode; in_ready is held low while reset is asserted
   always_comb begin
      w_in_ready = 1'b0;
      w_in_fire  = 1'b0;
      w_par_fire = 1'b0;
      case (r_state)
         MSG: begin
            w_in_ready = reset_n && w_out_load;
            w_in_fire  = bus.in_valid && w_in_ready;
         end
         PAR:     w_par_fire = w_out_load;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)        r_cnt <= '0;
      else if (w_in_fire)  r_cnt <= w_last_msg ? '0 : r_cnt + CNT_W'(1);
      else if (w_par_fire) r_cnt <= w_last_par ? '0 : r_cnt + CNT_W'(1);
   end

   // Division LFSR while absorbing; plain shift register while draining parity
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < int'(NUM_COEFS); j++) r_p[j] <= '0;
      end else if (w_in_fire) begin
         r_p[0] <= w_gp[0];
         for (int j = 1; j < int'(NUM_COEFS); j++) r_p[j] <= r_p[j-1] ^ w_gp[j];
      end else if (w_par_fire) begin
         r_p[0] <= '0;
         for (int j = 1; j < int'(NUM_COEFS); j++) r_p[j] <= r_p[j-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_in_fire) begin
         r_out_valid <= 1'b1;
         r_out       <= '{data: bus.in_data, sop: (r_cnt == '0), eop: 1'b0};
      end else if (w_par_fire) begin
         r_out_valid <= 1'b1;
         r_out       <= '{data: r_p[NUM_COEFS-1], sop: 1'b0, eop: w_last_par};
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
         r_out.sop   <= 1'b0;
         r_out.eop   <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out.data;
   assign bus.out_sop   = r_out.sop;
   assign bus.out_eop   = r_out.eop;

endmodule
